mc_alu: RTL
===========

MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 rst_i  input  1  asynchronous, active-high reset.
REQ-003 valid_i  input  1  operation request from ID/EX stage; sampled on rising edge.
REQ-004 ALUCtrl_i  input  3  op code: AND=000, XOR=001, SLL=010, ADD=011, SUB=100, MUL=101, ADDI=110, SRAI=111.
REQ-005 data1_i  input  32  operand A (rs1 value).
REQ-006 data2_i  input  32  operand B (rs2 value or sign-extended immediate).
REQ-007 data_o  output  32  registered result.
REQ-008 valid_o  output  1  one-cycle pulse; data_o holds a new result.
REQ-009 busy_o  output  1  stall request to hazard unit; high while a multi-cycle MUL is in progress.

Function
REQ-010 Request accepted on a rising edge when valid_i=1 and busy_o=0; valid_i while busy_o=1 is ignored, with no queuing.
REQ-011 Single-cycle ops (all except MUL): result written to data_o on the acceptance edge; valid_o=1 for exactly the following cycle.
REQ-012 AND: A&B; XOR: A^B; ADD/ADDI: A+B mod 2^32; SUB: A-B mod 2^32.
REQ-013 SLL: A << B[4:0], zero fill; SRAI: A >>> B[4:0], sign fill from A[31]; B[31:5] ignored.
REQ-014 MUL: data_o = low 32 bits of A*B, which is identical for signed and unsigned operands.
REQ-015 State machine has two states, IDLE and MULT; reset state IDLE.
REQ-016 IDLE->MULT: on acceptance of MUL. The acceptance edge loads multiplicand=A, multiplier=B, acc=0, cnt=0.
REQ-017 MULT, each edge: if multiplier[0] then acc+=multiplicand; multiplicand<<=1; multiplier>>=1; cnt+=1; all arithmetic mod 2^32.
REQ-018 MULT->IDLE: on the edge with cnt=31, i.e. the 32nd iteration. That edge writes the final acc to data_o and sets valid_o=1 for one cycle.
REQ-019 MUL latency: acceptance at edge T0 gives the result and valid_o pulse after edge T0+32.
REQ-020 busy_o = (state==MULT), driven from the state register only and not from inputs; high for 32 cycles per MUL.
REQ-021 Back-to-back: a new request presented in the cycle immediately after MULT->IDLE is accepted normally. A request during the final MULT cycle is ignored.
REQ-022 data_o holds its last value whenever valid_o=0.
REQ-023 valid_o is never high in two consecutive cycles for MUL. For single-cycle ops it may be high on consecutive cycles when valid_i is held high.

Reset
REQ-024 rst_i=1 immediately forces state=IDLE, data_o=0, valid_o=0, busy_o=0, cnt=0, acc=0, independent of clk_i.
REQ-025 Reset during MULT abandons the multiply with no valid_o pulse. The first edge after rst_i falls may accept a request.

Configuration
REQ-026 Macro MC_ALU_FAST_MUL_EN defined: MUL behaves as a single-cycle op per REQ-011 using a combinational 32x32 product. MULT is never entered and busy_o is constant 0.
REQ-027 Macro MC_ALU_FAST_MUL_EN undefined: iterative MUL per REQ-015..REQ-020. All other ops are identical in both builds.

Verification
REQ-028 ADD A=5, B=7, valid_i one cycle -> data_o=0x0000000C, valid_o high exactly the next cycle, busy_o stays 0.
REQ-029 SUB A=3, B=5 -> 0xFFFFFFFE; SRAI A=0x80000000, B=4 -> 0xF8000000; SLL A=1, B=0x00000025 -> 0x00000020 (shift 5).
REQ-030 MUL A=0xFFFFFFFF, B=3 -> busy_o high 32 cycles, then data_o=0xFFFFFFFD with a single valid_o pulse at T0+32. With MC_ALU_FAST_MUL_EN the same result arrives in 1 cycle and busy_o=0.
REQ-031 MUL A=6, B=7, then ADD A=1, B=1 held on valid_i throughout busy -> no response during busy. data_o=42 at T0+32, then the ADD is accepted after busy_o falls -> data_o=2.
REQ-032 MUL A=0x12345678, B=0x9ABCDEF0, with rst_i pulsed at cycle 10 of MULT -> outputs 0 immediately, no valid_o pulse. A subsequent XOR A=0xFF, B=0x0F -> 0xF0.

Source files
------------

// File: rtl/mc_alu_if.sv
// Request/response bundle between the ID/EX stage and mc_alu.
// Port names keep the pipeline's established _i/_o naming so existing hookups line up.
// slave = the ALU side, master = the pipeline/driver side.
interface mc_alu_if;
    logic        valid_i;
    logic [2:0]  ALUCtrl_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        busy_o;

    modport slave (
        input  valid_i, ALUCtrl_i, data1_i, data2_i,
        output data_o, valid_o, busy_o
    );

    modport master (
        output valid_i, ALUCtrl_i, data1_i, data2_i,
        input  data_o, valid_o, busy_o
    );
endinterface

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/shift/add ops, MUL by 32-step shift-add (or 1 cycle with MC_ALU_FAST_MUL_EN).
// Latency: 1 edge for single-cycle ops, result after acceptance edge + 32 for iterative MUL.
// Backpressure: busy_o high while a MUL iterates; requests seen while busy are dropped, not queued.
module mc_alu (
    input  logic    clk_i,
    input  logic    rst_i,
    mc_alu_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MULT = 1'b1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_ADDI = 3'b110;
    localparam logic [2:0] OP_SRAI = 3'b111;

`ifdef MC_ALU_FAST_MUL_EN
    // MUL is folded into the single-cycle result mux; the iterative path is never entered.
    localparam logic MUL_ITER = 1'b0;
`else
    localparam logic MUL_ITER = 1'b1;
`endif

    logic [0:0]  state;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [4:0]  cnt;
    logic [4:0]  shamt;
    logic [31:0] single_res;
    logic [31:0] acc_next;
    logic        is_mul;

    assign shamt      = bus.data2_i[4:0];
    assign is_mul     = (bus.ALUCtrl_i == OP_MUL);
    assign acc_next   = acc + (mplier[0] ? mcand : 32'd0);
    // busy comes from the state register only so the hazard unit never sees a combinational path from valid_i.
    assign bus.busy_o = (state == MULT);

    // Result of every operation that completes on the acceptance edge.
    always_comb begin
        single_res = 32'd0;
        case (bus.ALUCtrl_i)
            OP_AND:  single_res = bus.data1_i & bus.data2_i;
            OP_XOR:  single_res = bus.data1_i ^ bus.data2_i;
            OP_SLL:  single_res = bus.data1_i << shamt;
            OP_ADD:  single_res = bus.data1_i + bus.data2_i;
            OP_SUB:  single_res = bus.data1_i - bus.data2_i;
`ifdef MC_ALU_FAST_MUL_EN
            OP_MUL:  single_res = bus.data1_i * bus.data2_i;
`else
            OP_MUL:  single_res = 32'd0;
`endif
            OP_ADDI: single_res = bus.data1_i + bus.data2_i;
            OP_SRAI: single_res = 32'($signed(bus.data1_i) >>> shamt);
            default: single_res = 32'd0;
        endcase
    end

    // Accept requests in IDLE, iterate the shift-add multiplier in MULT, register results and the valid pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            mcand       <= 32'd0;
            mplier      <= 32'd0;
            acc         <= 32'd0;
            cnt         <= 5'd0;
            bus.data_o  <= 32'd0;
            bus.valid_o <= 1'b0;
        end else begin
            bus.valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid_i) begin
                        if (is_mul && MUL_ITER) begin
                            state  <= MULT;
                            mcand  <= bus.data1_i;
                            mplier <= bus.data2_i;
                            acc    <= 32'd0;
                            cnt    <= 5'd0;
                        end else begin
                            bus.data_o  <= single_res;
                            bus.valid_o <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    // 32nd iteration: publish the final partial sum directly.
                    if (cnt == 5'd31) begin
                        state       <= IDLE;
                        bus.data_o  <= acc_next;
                        bus.valid_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
